// File: rtl/prim4_pkg.sv
// Shared constants for the Prim4 self-test sweep: golden prime table,
// FSM state encoding and the last code of a sweep.
package prim4_pkg;

    localparam logic [15:0] PRIME_MASK = 16'h28AC;
    localparam logic [3:0]  SWEEP_LAST = 4'd15;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_SETTLE = 2'd1;
    localparam logic [1:0] ENC_CHECK  = 2'd2;
    localparam logic [1:0] ENC_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SETTLE = ENC_SETTLE,
        ST_CHECK  = ENC_CHECK,
        ST_DONE   = ENC_DONE
    } state_e;

endpackage

// File: rtl/prim4_ref.sv
// Golden combinational model of the 4-bit prime detector: code -> is-prime.
module prim4_ref
    import prim4_pkg::*;
(
    input  logic [3:0] code,
    output logic       expected
);

    assign expected = PRIME_MASK[code];

endmodule

// File: rtl/prim4_sweep.sv
// Self-test engine: steps S through 0..15, waits SETTLE cycles per code,
// compares prim_in against the golden table and accumulates results.
module prim4_sweep
    import prim4_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] S,
    input  logic       prim_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic       fv_q, fv_d;
    logic [3:0] ff_q, ff_d;
    logic       pass_q, pass_d;
    logic       exp_bit;

    prim4_ref u_ref (
        .code     (s_q),
        .expected (exp_bit)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = 4'd0;
                    err_d   = 5'd0;
                    fv_d    = 1'b0;
                    ff_d    = 4'd0;
                    pass_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                // Case inequality so an unknown response is scored as a mismatch.
                if (prim_in !== exp_bit) begin
                    err_d = err_q + 5'd1;
                    fv_d  = 1'b1;
                    if (!fv_q) begin
                        ff_d = s_q;
                    end
                end
                if (s_q == SWEEP_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    s_d     = s_q + 4'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                pass_d  = (err_q == 5'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            fv_q    <= 1'b0;
            ff_q    <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign S          = s_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;
    assign pass       = pass_q;

endmodule
